// File: rtl/pool_pkg.sv
// ============================================================================
// Module   : pool_pkg
// Purpose  : Shared types, dimension constants and helpers for pool_sched.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pool_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_CMPL  = 3'd4
    } state_e;

    localparam logic [2:0] DIM_3 = 3'd3;
    localparam logic [2:0] DIM_4 = 3'd4;
    localparam logic [2:0] DIM_5 = 3'd5;

    // Channel stride in words; zero for dimensions the pooling unit cannot run.
    function automatic logic [4:0] dim_sq(input logic [2:0] dim);
        case (dim)
            DIM_3:   return 5'd9;
            DIM_4:   return 5'd16;
            DIM_5:   return 5'd25;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic dim_legal(input logic [2:0] dim);
        return (dim == DIM_3) || (dim == DIM_4) || (dim == DIM_5);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pool_sched_if.sv
// ============================================================================
// Module   : pool_sched_if
// Purpose  : Requester, pooling-controller and completion signals of pool_sched.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pool_sched_if #(
    parameter int N_REQ  = 4,
    parameter int CH_W   = 6,
    parameter int ADDR_W = 10
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0]             req_ready;
    logic [N_REQ-1:0][2:0]        req_inst;
    logic [N_REQ-1:0][2:0]        req_dim;
    logic [N_REQ-1:0][CH_W-1:0]   req_nch;
    logic [N_REQ-1:0][ADDR_W-1:0] req_base;

    logic                         start_pool;
    logic [2:0]                   pooling_inst;
    logic [2:0]                   array_dim;
    logic [ADDR_W-1:0]            ch_base;
    logic                         pu_done;

    logic                         cmp_valid;
    logic [ID_W-1:0]              cmp_id;
    logic                         cmp_err;
    logic                         busy;

    modport master (
        output req_valid, req_inst, req_dim, req_nch, req_base, pu_done,
        input  req_ready, start_pool, pooling_inst, array_dim, ch_base,
               cmp_valid, cmp_id, cmp_err, busy
    );

    modport slave (
        input  req_valid, req_inst, req_dim, req_nch, req_base, pu_done,
        output req_ready, start_pool, pooling_inst, array_dim, ch_base,
               cmp_valid, cmp_id, cmp_err, busy
    );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : One-hot grant to the first valid requester at or after ptr.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [PW:0] idx;
    logic        found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr} + (PW + 1)'(i);
            if (idx >= (PW + 1)'(N)) begin
                idx = idx - (PW + 1)'(N);
            end
            if (!found && valid[idx[PW-1:0]]) begin
                grant[idx[PW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pool_sched.sv
// ============================================================================
// Module   : pool_sched
// Purpose  : Round-robin job scheduler feeding a shared pooling unit, one
//            channel at a time, with per-channel timeout and completion report.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pool_sched
    import pool_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int CH_W    = 6,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    pool_sched_if.slave bus
);

    localparam int             ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int             TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_e            state_q,      state_d;
    logic [ID_W-1:0]   ptr_q,        ptr_d;
    logic [ID_W-1:0]   id_q,         id_d;
    logic [2:0]        inst_q,       inst_d;
    logic [2:0]        dim_q,        dim_d;
    logic [CH_W-1:0]   nch_q,        nch_d;
    logic [ADDR_W-1:0] base_q,       base_d;
    logic [CH_W-1:0]   ch_cnt_q,     ch_cnt_d;
    logic [TMO_W-1:0]  tmo_q,        tmo_d;
    logic              start_pool_q, start_pool_d;
    logic              cmp_valid_q,  cmp_valid_d;
    logic              cmp_err_q,    cmp_err_d;
    logic              busy_q,       busy_d;
    logic              ready_en_q,   ready_en_d;

    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   sel_id;
    logic              accept;
    logic              sel_legal;
    logic [ADDR_W-1:0] stride;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (ID_W)
    ) u_arb (
        .valid (bus.req_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_comb begin
        sel_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_id = ID_W'(i);
            end
        end
    end

    // ready_en_q is a registered "in IDLE and out of reset" flag, so
    // req_ready is forced low while rst is held even if req_valid is high.
    assign accept    = ready_en_q && (|grant);
    assign sel_legal = dim_legal(bus.req_dim[sel_id]) && (bus.req_nch[sel_id] != '0);
    assign stride    = ADDR_W'(dim_sq(dim_q));

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        inst_d       = inst_q;
        dim_d        = dim_q;
        nch_d        = nch_q;
        base_d       = base_q;
        ch_cnt_d     = ch_cnt_q;
        tmo_d        = tmo_q;
        cmp_err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    id_d     = sel_id;
                    inst_d   = bus.req_inst[sel_id];
                    dim_d    = bus.req_dim[sel_id];
                    nch_d    = bus.req_nch[sel_id];
                    base_d   = bus.req_base[sel_id];
                    ptr_d    = (sel_id == ID_W'(N_REQ - 1)) ? '0 : sel_id + 1'b1;
                    ch_cnt_d = '0;
                    tmo_d    = '0;
                    if (sel_legal) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d   = ST_CMPL;
                        cmp_err_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // pu_done takes priority over an expiring timeout.
                if (bus.pu_done) begin
                    state_d = ST_NEXT;
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = ST_CMPL;
                    cmp_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_NEXT: begin
                ch_cnt_d = ch_cnt_q + 1'b1;
                base_d   = base_q + stride;
                if (ch_cnt_q == nch_q - CH_W'(1)) begin
                    state_d = ST_CMPL;
                end else begin
                    state_d = ST_ISSUE;
                    tmo_d   = '0;
                end
            end
            ST_CMPL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        start_pool_d = (state_d == ST_ISSUE);
        cmp_valid_d  = (state_d == ST_CMPL);
        busy_d       = (state_d != ST_IDLE);
        ready_en_d   = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            inst_q       <= '0;
            dim_q        <= '0;
            nch_q        <= '0;
            base_q       <= '0;
            ch_cnt_q     <= '0;
            tmo_q        <= '0;
            start_pool_q <= 1'b0;
            cmp_valid_q  <= 1'b0;
            cmp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            inst_q       <= inst_d;
            dim_q        <= dim_d;
            nch_q        <= nch_d;
            base_q       <= base_d;
            ch_cnt_q     <= ch_cnt_d;
            tmo_q        <= tmo_d;
            start_pool_q <= start_pool_d;
            cmp_valid_q  <= cmp_valid_d;
            cmp_err_q    <= cmp_err_d;
            busy_q       <= busy_d;
            ready_en_q   <= ready_en_d;
        end
    end

    assign bus.req_ready    = ready_en_q ? grant : '0;
    assign bus.start_pool   = start_pool_q;
    assign bus.pooling_inst = inst_q;
    assign bus.array_dim    = dim_q;
    assign bus.ch_base      = base_q;
    assign bus.cmp_valid    = cmp_valid_q;
    assign bus.cmp_id       = id_q;
    assign bus.cmp_err      = cmp_err_q;
    assign bus.busy         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_pool_sched.sv
// ============================================================================
// Module   : tb_pool_sched
// Purpose  : Scoreboard bench for pool_sched (main instance plus a narrow
//            address instance for base wrap-around).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pool_sched;

    localparam int N_REQ   = 4;
    localparam int CH_W    = 6;
    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 64;
    localparam int ID_W    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pool_sched_if #(.N_REQ(N_REQ), .CH_W(CH_W), .ADDR_W(ADDR_W)) bus  ();
    pool_sched_if #(.N_REQ(N_REQ), .CH_W(CH_W), .ADDR_W(5))      bus2 ();

    pool_sched #(.N_REQ(N_REQ), .CH_W(CH_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pool_sched #(.N_REQ(N_REQ), .CH_W(CH_W), .ADDR_W(5), .TIMEOUT(TIMEOUT)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [2:0]        inst;
        logic [2:0]        dim;
        int                lat;
    } st_exp_t;

    typedef struct {
        int   id;
        logic err;
        int   lat_acc;
        int   lat_start;
    } cmp_exp_t;

    st_exp_t          st_q[$];
    cmp_exp_t         cmp_q[$];
    st_exp_t          mon_s;
    cmp_exp_t         mon_c;

    int               n_cmp     = 0;
    int               n_bad     = 0;
    int               cyc       = 0;
    int               acc_cyc   = 0;
    int               start_cyc = 0;
    int               pu_delay  = 5;
    logic [N_REQ-1:0] drop_mask = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Expected starts and completion are queued at drive time.
    task automatic submit(input logic [ID_W-1:0] id, input logic [2:0] inst,
                          input logic [2:0] dim, input int nch, input int base,
                          input bit tmo);
        st_exp_t  s;
        cmp_exp_t c;
        bit       legal;
        int       sq;
        legal = (dim >= 3'd3) && (dim <= 3'd5) && (nch != 0);
        sq    = int'(dim) * int'(dim);
        if (legal) begin
            for (int k = 0; k < nch; k++) begin
                s.base = ADDR_W'(base + k * sq);
                s.inst = inst;
                s.dim  = dim;
                s.lat  = (k == 0) ? 1 : -1;
                st_q.push_back(s);
            end
        end
        c.id        = int'(id);
        c.err       = !legal || tmo;
        c.lat_acc   = legal ? -1 : 2;
        c.lat_start = tmo ? TIMEOUT + 1 : -1;
        cmp_q.push_back(c);
        bus.req_inst[id]  = inst;
        bus.req_dim[id]   = dim;
        bus.req_nch[id]   = CH_W'(nch);
        bus.req_base[id]  = ADDR_W'(base);
        bus.req_valid[id] = 1'b1;
    endtask

    task automatic wait_drain(input string tag, input int max);
        int n;
        n = 0;
        while ((bus.req_valid != '0 || bus.busy || cmp_q.size() != 0) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " drain timeout"}, 32'(n >= max), 32'd0);
        chk({tag, " starts left over"}, 32'(st_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic outputs_zero(input string pfx);
        chk({pfx, " start_pool"},   32'(bus.start_pool),   32'd0);
        chk({pfx, " cmp_valid"},    32'(bus.cmp_valid),    32'd0);
        chk({pfx, " cmp_err"},      32'(bus.cmp_err),      32'd0);
        chk({pfx, " busy"},         32'(bus.busy),         32'd0);
        chk({pfx, " req_ready"},    32'(bus.req_ready),    32'd0);
        chk({pfx, " pooling_inst"}, 32'(bus.pooling_inst), 32'd0);
        chk({pfx, " array_dim"},    32'(bus.array_dim),    32'd0);
        chk({pfx, " ch_base"},      32'(bus.ch_base),      32'd0);
        chk({pfx, " cmp_id"},       32'(bus.cmp_id),       32'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Drop a requester's valid just after the edge that accepted it.
    initial forever begin
        @(posedge clk);
        #1;
        if (drop_mask != '0) begin
            bus.req_valid = bus.req_valid & ~drop_mask;
            drop_mask     = '0;
        end
    end

    // Pooling-unit model: answers each start after pu_delay cycles (never if < 0).
    initial begin
        bus.pu_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.start_pool && pu_delay >= 0) begin
                repeat (pu_delay) @(negedge clk);
                bus.pu_done = 1'b1;
                @(negedge clk);
                bus.pu_done = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if ((bus.req_valid & bus.req_ready) != '0) begin
                acc_cyc   = cyc;
                drop_mask = bus.req_valid & bus.req_ready;
            end
            if (bus.start_pool) begin
                start_cyc = cyc;
                if (st_q.size() == 0) begin
                    chk("spurious start_pool", 32'(bus.start_pool), 32'd0);
                end else begin
                    mon_s = st_q.pop_front();
                    chk("ch_base", 32'(bus.ch_base), 32'(mon_s.base));
                    chk("pooling_inst", 32'(bus.pooling_inst), 32'(mon_s.inst));
                    chk("array_dim", 32'(bus.array_dim), 32'(mon_s.dim));
                    if (mon_s.lat >= 0) chk("start latency", 32'(cyc - acc_cyc), 32'(mon_s.lat));
                end
            end
            if (bus.cmp_valid) begin
                if (cmp_q.size() == 0) begin
                    chk("spurious cmp_valid", 32'(bus.cmp_valid), 32'd0);
                end else begin
                    mon_c = cmp_q.pop_front();
                    chk("cmp_id", 32'(bus.cmp_id), 32'(mon_c.id));
                    chk("cmp_err", 32'(bus.cmp_err), 32'(mon_c.err));
                    if (mon_c.lat_acc >= 0)
                        chk("cmp latency from accept", 32'(cyc - acc_cyc + 1), 32'(mon_c.lat_acc));
                    if (mon_c.lat_start >= 0)
                        chk("cmp latency from start", 32'(cyc - start_cyc), 32'(mon_c.lat_start));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d expected completions pending", cmp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int               n;
        int               got;
        logic [4:0]       wb [2];

        bus.req_valid  = '0;
        bus.req_inst   = '0;
        bus.req_dim    = '0;
        bus.req_nch    = '0;
        bus.req_base   = '0;
        bus2.req_valid = '0;
        bus2.req_inst  = '0;
        bus2.req_dim   = '0;
        bus2.req_nch   = '0;
        bus2.req_base  = '0;
        bus2.pu_done   = 1'b0;

        // Reset state, with every requester asking so req_ready must stay low.
        bus.req_valid = '1;
        repeat (3) @(negedge clk);
        outputs_zero("reset");
        bus.req_valid = '0;
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Fairness: all four valid from pointer 0.
        pu_delay = 3;
        @(posedge clk); #2;
        for (int i = 0; i < N_REQ; i++)
            submit(ID_W'(i), 3'(i), 3'd3, 1, 100 * i, 1'b0);
        wait_drain("fairness", 400);

        // req0 alone, then req2 and req0 while the first job runs: 2 before 0.
        @(posedge clk); #2;
        submit(2'd0, 3'b100, 3'd5, 1, 7, 1'b0);
        n = 0;
        while (bus.req_valid[0] && n < 50) begin @(negedge clk); n++; end
        chk("req0 accept timeout", 32'(n >= 50), 32'd0);
        @(posedge clk); #2;
        submit(2'd2, 3'b001, 3'd4, 1, 300, 1'b0);
        submit(2'd0, 3'b110, 3'd3, 1, 500, 1'b0);
        wait_drain("rr order", 400);

        // Single three-channel job, done five cycles after each start.
        pu_delay = 5;
        @(posedge clk); #2;
        submit(2'd0, 3'b100, 3'd4, 3, 0, 1'b0);
        wait_drain("single job", 400);

        // Illegal requests.
        @(posedge clk); #2;
        submit(2'd1, 3'b100, 3'd6, 2, 0, 1'b0);
        wait_drain("illegal dim", 50);
        @(posedge clk); #2;
        submit(2'd3, 3'b000, 3'd4, 0, 40, 1'b0);
        wait_drain("illegal nch", 50);

        // Timeout with no pu_done at all.
        pu_delay = -1;
        @(posedge clk); #2;
        submit(2'd2, 3'b001, 3'd3, 1, 50, 1'b1);
        wait_drain("timeout", 300);
        chk("busy after timeout", 32'(bus.busy), 32'd0);

        // pu_done on the very cycle the timeout would fire.
        pu_delay = TIMEOUT;
        @(posedge clk); #2;
        submit(2'd1, 3'b100, 3'd3, 2, 5, 1'b0);
        wait_drain("done at timeout", 400);

        // Reset while waiting for pu_done.
        pu_delay = -1;
        @(posedge clk); #2;
        submit(2'd3, 3'b101, 3'd4, 2, 200, 1'b0);
        n = 0;
        while (st_q.size() != 1 && n < 50) begin @(negedge clk); n++; end
        chk("mid-job start timeout", 32'(n >= 50), 32'd0);
        repeat (5) @(negedge clk);
        bus.req_inst[1]  = 3'b000;
        bus.req_dim[1]   = 3'd5;
        bus.req_nch[1]   = CH_W'(2);
        bus.req_base[1]  = '0;
        bus.req_valid[1] = 1'b1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("cmp_valid in reset", 32'(bus.cmp_valid), 32'd0);
        end
        outputs_zero("mid-job reset");
        st_q.delete();
        cmp_q.delete();
        bus.req_valid = '0;
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        pu_delay = 2;
        @(posedge clk); #2;
        submit(2'd1, 3'b000, 3'd5, 2, 0, 1'b0);
        wait_drain("after reset", 200);

        // Narrow-address instance: 20 + 25 wraps to 13 in 5 bits.
        @(posedge clk); #2;
        bus2.req_inst[0]  = 3'b100;
        bus2.req_dim[0]   = 3'd5;
        bus2.req_nch[0]   = CH_W'(2);
        bus2.req_base[0]  = 5'd20;
        bus2.req_valid[0] = 1'b1;
        got   = 0;
        n     = 0;
        wb[0] = '0;
        wb[1] = '0;
        while (got < 2 && n < 200) begin
            @(negedge clk);
            n++;
            if (bus2.start_pool) begin
                wb[got]           = bus2.ch_base;
                got++;
                bus2.req_valid[0] = 1'b0;
                @(negedge clk);
                bus2.pu_done = 1'b1;
                @(negedge clk);
                bus2.pu_done = 1'b0;
            end
        end
        chk("wrap start count", 32'(got), 32'd2);
        chk("wrap ch_base 0", 32'(wb[0]), 32'd20);
        chk("wrap ch_base 1", 32'(wb[1]), 32'd13);
        n = 0;
        while (!bus2.cmp_valid && n < 50) begin @(negedge clk); n++; end
        chk("wrap cmp timeout", 32'(n >= 50), 32'd0);
        chk("wrap cmp_err", 32'(bus2.cmp_err), 32'd0);
        chk("wrap cmp_id", 32'(bus2.cmp_id), 32'd0);
        @(negedge clk);
        chk("wrap busy after", 32'(bus2.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pool_sched.md
POOL_SCHED -- requirements
Module: pool_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the pooling unit.
REQ-002 Parameter CH_W, default 6: width of the channel-count field.
REQ-003 Parameter ADDR_W, default 10: width of the base-address field.
REQ-004 Parameter TIMEOUT, default 64: maximum cycles to wait for pu_done per channel.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  N_REQ  request pending, one bit per requester.
REQ-008 req_ready  out  N_REQ  one-hot accept; request i is taken when req_valid[i] and req_ready[i] are both high.
REQ-009 req_inst  in  N_REQ x 3  pooling instruction per requester; bit 2 selects max (1) or avg (0).
REQ-010 req_dim  in  N_REQ x 3  feature-map dimension per requester; legal values are 3, 4 and 5.
REQ-011 req_nch  in  N_REQ x CH_W  number of channels to pool.
REQ-012 req_base  in  N_REQ x ADDR_W  base address of channel 0.
REQ-013 start_pool  out  1  one-cycle start pulse to the pooling controller.
REQ-014 pooling_inst  out  3  latched instruction.
REQ-015 array_dim  out  3  latched dimension.
REQ-016 ch_base  out  ADDR_W  base address of the current channel.
REQ-017 pu_done  in  1  pooling controller has finished the current channel.
REQ-018 cmp_valid  out  1  one-cycle completion pulse.
REQ-019 cmp_id  out  $clog2(N_REQ)  index of the completed requester.
REQ-020 cmp_err  out  1  completion carries an error (illegal request or timeout).
REQ-021 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-022 FSM states SHALL be IDLE, ISSUE, WAIT, NEXT and CMPL.
REQ-023 In IDLE, req_ready SHALL be one-hot on the first valid requester at or after the round-robin pointer, wrapping from N_REQ-1 to 0; it SHALL be all-zero when no request is valid or the FSM is not in IDLE.
REQ-024 On accept, the block SHALL:
- latch inst, dim, nch, base and id;
- set the pointer to (id+1) mod N_REQ;
- clear ch_cnt and the timeout counter;
- go to ISSUE.
REQ-025 If the accepted request has dim not in {3,4,5} or nch==0, the FSM SHALL go to CMPL with cmp_err=1 and SHALL never assert start_pool for it.
REQ-026 In ISSUE, start_pool SHALL be 1 for exactly one cycle, and the FSM SHALL then go to WAIT; start_pool SHALL occur one cycle after the accept edge.
REQ-027 pooling_inst, array_dim and ch_base SHALL remain stable from ISSUE until the FSM leaves WAIT.
REQ-028 pu_done SHALL be sampled only in WAIT and ignored in every other state, including the ISSUE cycle.
REQ-029 In WAIT, pu_done=1 SHALL move the FSM to NEXT.
REQ-030 In WAIT, if the timeout counter reaches TIMEOUT-1 without pu_done, the FSM SHALL go to CMPL with cmp_err=1.
REQ-031 If pu_done and the timeout occur in the same cycle, pu_done SHALL win.
REQ-032 In NEXT, the block SHALL:
- set ch_cnt to ch_cnt+1;
- set ch_base to ch_base + dim*dim (9, 16 or 25), modulo 2^ADDR_W with silent wrap;
- go to CMPL if the old ch_cnt equals nch-1, otherwise to ISSUE with a fresh timeout count.
REQ-033 In CMPL, cmp_valid SHALL be 1 for one cycle with cmp_id = latched id and cmp_err as determined above, and the FSM SHALL then return to IDLE.
REQ-034 A requester SHALL be accepted again no earlier than the cycle after its cmp_valid.
REQ-035 req_valid deasserting after accept SHALL have no effect on the running job.

Reset
REQ-036 While rst is high the block SHALL hold:
- state IDLE;
- pointer 0;
- ch_cnt, timeout counter and all latched fields at 0;
- start_pool, cmp_valid, cmp_err, busy and req_ready at 0;
- pooling_inst, array_dim, ch_base and cmp_id at 0.
REQ-037 Reset asserted mid-job SHALL abort the job with no cmp_valid, and after release the block SHALL accept new requests normally.

Structure
REQ-038 A shared package pool_pkg SHALL hold the state enum, the DIM_3/DIM_4/DIM_5 constants and a dim-squared function.
REQ-039 Round-robin selection SHALL be implemented in the sub-module rr_arbiter (parameter N, inputs valid and ptr, output one-hot grant).

Verification
REQ-040 Single job: req0 with dim=4, nch=3, base=0, done returned 5 cycles after each start -> three start_pool pulses at ch_base 0, 16, 32, then cmp_valid with id=0, err=0.
REQ-041 Fairness: req0..3 all valid and each job nch=1 -> grants in order 0,1,2,3; req0 re-asserted plus req2 after the 0 grant -> the next grant goes to 2 before 0.
REQ-042 Illegal request: dim=6 or nch=0 -> no start_pool, cmp_valid with err=1 two cycles after accept.
REQ-043 Timeout: pu_done never returned, TIMEOUT=64 -> cmp_err=1 and busy=0 afterwards; pu_done together with the timeout cycle -> normal progress with no error.
REQ-044 Wrap: ADDR_W=5, base=20, dim=5, nch=2 -> second ch_base = 13.
REQ-045 Reset mid-WAIT: no cmp_valid is produced, all outputs are 0, and a new request is accepted and completes normally.
